// File: rtl/serial_rx_controller.sv
// Serial-to-parallel receiver: frame sync, LSB-first assembly,
// a one-word output buffer on valid/ready, and sticky error flags.
module serial_rx_controller #(
  parameter int N          = 8,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         sync_in,
  input  logic         data_in,
  input  logic         clear_err,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic         overrun,
  output logic         frame_abort
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          abt_q, abt_d;
  logic          done, set_abt, load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    done    = 1'b0;
    set_abt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && sync_in) begin
          sh_d[0] = data_in;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!enable) begin
          set_abt = (cnt_q != '0);
          cnt_d   = '0;
          state_d = IDLE;
        end else if (sync_in && cnt_q != '0) begin
          // resync mid-word: restart with this bit as bit 0
          set_abt = 1'b1;
          sh_d[0] = data_in;
          cnt_d   = CW'(1);
        end else begin
          sh_d[cnt_q] = data_in;
          if (cnt_q == LAST) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = CONTINUOUS ? SHIFT : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load    = done && (!valid_q || out_ready);
    valid_d = load || (valid_q && !out_ready);
    data_d  = load ? sh_d : data_q;
    ovr_d   = (ovr_q && !clear_err) || (done && valid_q && !out_ready);
    abt_d   = (abt_q && !clear_err) || set_abt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      abt_q   <= abt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign busy        = (state_q == SHIFT);
  assign overrun     = ovr_q;
  assign frame_abort = abt_q;

endmodule

// File: tb/tb_serial_rx_controller.sv
// Bench for serial_rx_controller: three configurations share one
// stimulus stream and are checked each cycle against a word-level model.
module tb_serial_rx_controller;

  logic clk = 1'b0;
  logic reset, en, sync, din, clr, rdy;

  logic       ova, ovb, ovc;
  logic [7:0] oda, odb;
  logic [1:0] odc;
  logic       bza, bzb, bzc;
  logic       ora, orb, orc;
  logic       aba, abb, abc;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_rx_controller #(.N(8), .CONTINUOUS(1'b0)) u0 (
    .clk(clk), .reset(reset), .enable(en), .sync_in(sync),
    .data_in(din), .clear_err(clr), .out_ready(rdy),
    .out_valid(ova), .out_data(oda), .busy(bza),
    .overrun(ora), .frame_abort(aba));

  serial_rx_controller #(.N(8), .CONTINUOUS(1'b1)) u1 (
    .clk(clk), .reset(reset), .enable(en), .sync_in(sync),
    .data_in(din), .clear_err(clr), .out_ready(rdy),
    .out_valid(ovb), .out_data(odb), .busy(bzb),
    .overrun(orb), .frame_abort(abb));

  serial_rx_controller #(.N(2), .CONTINUOUS(1'b1)) u2 (
    .clk(clk), .reset(reset), .enable(en), .sync_in(sync),
    .data_in(din), .clear_err(clr), .out_ready(rdy),
    .out_valid(ovc), .out_data(odc), .busy(bzc),
    .overrun(orc), .frame_abort(abc));

  int   ns [3] = '{8, 8, 2};
  bit   cs [3] = '{1'b0, 1'b1, 1'b1};
  bit   mact [3];
  int   mgot [3];
  logic [7:0] macc [3];
  bit   mov [3];
  logic [7:0] mod [3];
  bit   movr [3];
  bit   mabt [3];

  task automatic chk(input string nm, input logic [7:0] a,
                     input logic [7:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mact[k] = 0; mgot[k] = 0; macc[k] = '0;
      mov[k] = 0; mod[k] = '0; movr[k] = 0; mabt[k] = 0;
    end
  endtask

  // One clock of receiver behaviour, in terms of bits collected so far.
  task automatic model_step(input int k);
    bit done, sa, so;
    int mk;
    done = 0; sa = 0; so = 0;
    mk = (1 << ns[k]) - 1;
    if (!mact[k]) begin
      if (en && sync) begin
        macc[k][0] = din; mgot[k] = 1; mact[k] = 1;
      end
    end else if (!en) begin
      sa = (mgot[k] != 0); mgot[k] = 0; mact[k] = 0;
    end else if (sync && mgot[k] != 0) begin
      sa = 1; macc[k][0] = din; mgot[k] = 1;
    end else begin
      macc[k][mgot[k]] = din;
      if (mgot[k] == ns[k] - 1) begin
        done = 1; mgot[k] = 0; mact[k] = cs[k];
      end else begin
        mgot[k]++;
      end
    end
    if (done) begin
      if (!mov[k] || rdy) begin
        mod[k] = macc[k] & mk[7:0]; mov[k] = 1;
      end else begin
        so = 1;
      end
    end else if (mov[k] && rdy) begin
      mov[k] = 0;
    end
    movr[k] = (movr[k] && !clr) || so;
    mabt[k] = (mabt[k] && !clr) || sa;
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else for (int k = 0; k < 3; k++) model_step(k);
    #1;
    chk("u0.valid", {7'd0, ova}, {7'd0, mov[0]});
    if (mov[0]) chk("u0.data", oda, mod[0]);
    chk("u0.busy", {7'd0, bza}, {7'd0, mact[0]});
    chk("u0.ovr", {7'd0, ora}, {7'd0, movr[0]});
    chk("u0.abt", {7'd0, aba}, {7'd0, mabt[0]});
    chk("u1.valid", {7'd0, ovb}, {7'd0, mov[1]});
    if (mov[1]) chk("u1.data", odb, mod[1]);
    chk("u1.busy", {7'd0, bzb}, {7'd0, mact[1]});
    chk("u1.ovr", {7'd0, orb}, {7'd0, movr[1]});
    chk("u1.abt", {7'd0, abb}, {7'd0, mabt[1]});
    chk("u2.valid", {7'd0, ovc}, {7'd0, mov[2]});
    if (mov[2]) chk("u2.data", {6'd0, odc}, mod[2]);
    chk("u2.busy", {7'd0, bzc}, {7'd0, mact[2]});
    chk("u2.ovr", {7'd0, orc}, {7'd0, movr[2]});
    chk("u2.abt", {7'd0, abc}, {7'd0, mabt[2]});
  end

  task automatic cyc(input bit e, input bit s, input bit d,
                     input bit r, input bit c);
    en = e; sync = s; din = d; rdy = r; clr = c;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] w, input int n, input bit s0,
                      input bit r, input bit rlast);
    for (int i = 0; i < n; i++)
      cyc(1'b1, s0 && i == 0, w[i], (i == n - 1) ? rlast : r, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    model_reset();
    reset = 1'b1; en = 0; sync = 0; din = 0; clr = 0; rdy = 0;
    @(negedge clk);
    chk("rst.valid", {7'd0, ova}, 8'd0);
    chk("rst.data", oda, 8'd0);
    chk("rst.busy", {7'd0, bza}, 8'd0);
    chk("rst.flags", {6'd0, ora, aba}, 8'd0);
    reset = 1'b0;

    // single word A5
    w = 8'hA5;
    cyc(1'b1, 1'b1, w[0], 1'b1, 1'b0);
    chk("t1.busy1", {7'd0, bza}, 8'd1);
    chk("t1.novalid", {7'd0, ova}, 8'd0);
    for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, w[i], 1'b1, 1'b0);
    chk("t1.valid", {7'd0, ova}, 8'd1);
    chk("t1.data", oda, 8'hA5);
    chk("t1.flags", {6'd0, ora, aba}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1.drained", {7'd0, ova}, 8'd0);

    // backpressure and overrun
    do_reset();
    send(8'h3C, 8, 1'b1, 1'b0, 1'b0);
    send(8'hC3, 8, 1'b1, 1'b0, 1'b0);
    chk("t2.hold", oda, 8'h3C);
    chk("t2.ovr", {7'd0, ora}, 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2.xfer", {7'd0, ova}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2.clr", {7'd0, ora}, 8'd0);

    // simultaneous drain and load, continuous stream
    do_reset();
    send(8'h01, 8, 1'b1, 1'b0, 1'b1);
    chk("t3.w1", odb, 8'h01);
    send(8'h02, 8, 1'b0, 1'b0, 1'b1);
    chk("t3.w2", odb, 8'h02);
    chk("t3.v2", {7'd0, ovb}, 8'd1);
    send(8'h03, 8, 1'b0, 1'b0, 1'b1);
    chk("t3.w3", odb, 8'h03);
    chk("t3.ovr", {7'd0, orb}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // resync at count 4
    do_reset();
    send(8'hFF, 4, 1'b1, 1'b1, 1'b1);
    send(8'h5A, 8, 1'b1, 1'b1, 1'b1);
    chk("t4.data", oda, 8'h5A);
    chk("t4.abt", {7'd0, aba}, 8'd1);

    // enable drop with a word pending, then async reset mid-word
    do_reset();
    send(8'h3C, 8, 1'b1, 1'b0, 1'b0);
    send(8'h0F, 5, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5.idle", {7'd0, bza}, 8'd0);
    chk("t5.abt", {7'd0, aba}, 8'd1);
    chk("t5.keep", oda, 8'h3C);
    chk("t5.kvalid", {7'd0, ova}, 8'd1);
    send(8'h00, 3, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t5.rst", {4'd0, ova, bza, ora, aba}, 8'd0);
    chk("t5.rstd", oda, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    send(8'hFF, 8, 1'b1, 1'b1, 1'b1);
    chk("t5.ff", oda, 8'hFF);
    chk("t5.ffabt", {7'd0, aba}, 8'd0);

    // N=2 continuous stream: 2'b10 then 2'b01
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6.w1", {6'd0, odc}, 8'h02);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6.w2", {6'd0, odc}, 8'h01);
    chk("t6.v2", {7'd0, ovc}, 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
